cwp_window_ctrl: RTL and testbench
==================================

// Module: cwp_window_ctrl
// PURPOSE
//  Register-window controller for the CPIPE1 control path. Acts on decoded call/return pulses (the changeCWP*
//  class of control outputs) and maintains CWP, the oldest resident window SWP and an in-memory save stack.
//  On window overflow it spills the oldest window to memory; on underflow it fills it back. Both sequences
//  use a req/ack memory handshake and hold the pipeline stalled until they complete.
// PARAMETERS
//  NWIN          8        number of physical windows, power of 2; at most NWIN-1 windows are resident
//  CWPW          3        CWP/SWP width; must equal log2(NWIN)
//  REGS_PER_WIN  16       registers moved per spill/fill, power of 2
//  RIW           4        register-index width; must equal log2(REGS_PER_WIN)
//  AW            16       memory word-address width
//  STACK_TOP     16'hFFF0 reset value of SAVEPTR; the save stack grows downward
// PORTS
//  CLK           in   1    clock, rising edge
//  RESET_N       in   1    asynchronous, active-low reset
//  WAIT          in   1    global pipeline wait; call/ret are not accepted while it is high
//  changeCWPcall in   1    call decoded this cycle (single-cycle pulse)
//  changeCWPret  in   1    return decoded this cycle (single-cycle pulse)
//  memAck        in   1    memory accepted the current transfer (read data valid when memWrite=0)
//  memRdata      in   32   fill read data
//  CWP           out  CWPW current window pointer
//  SWP           out  CWPW oldest resident window
//  memReq        out  1    transfer request
//  memWrite      out  1    1=spill write, 0=fill read
//  memAddr       out  AW   transfer word address
//  regIdx        out  RIW  register within the window being moved
//  memWdata      out  32   spill data; mirrors regRdata
//  regRdata      in   32   register-file read data for (SWP,regIdx), combinational
//  regWe         out  1    fill write strobe to register file at (SWP-1,regIdx)
//  stallPipe     out  1    high whenever state != IDLE
//  retErr        out  1    1-cycle pulse: return with nothing to restore
//  stackOvf      out  1    1-cycle pulse: call needs a spill but DEPTH==255
// BEHAVIOUR
//  Reset values: CWP=0, SWP=0, OCC=1, DEPTH=0, SAVEPTR=STACK_TOP, state IDLE, all strobes, memReq and regIdx 0.
//  Internal state: OCC = resident windows (1..NWIN-1); DEPTH = spilled windows (8-bit).
//  Accept: call/ret are sampled only in IDLE with WAIT=0. Call and ret high together is a no-op.
//  Call/ret pulses arriving while busy are ignored.
//  Call, OCC<NWIN-1: next edge CWP+=1 (mod NWIN), OCC+=1.
//  Call, OCC==NWIN-1, DEPTH<255: go to SPILL. Call, OCC==NWIN-1, DEPTH==255: stackOvf pulse, no state change.
//  Ret, OCC>1: next edge CWP-=1, OCC-=1.
//  Ret, OCC==1, DEPTH>0: go to FILL. Ret, OCC==1, DEPTH==0: retErr pulse, no state change.
//  SPILL: memReq=1, memWrite=1, memAddr=SAVEPTR-REGS_PER_WIN+regIdx.
//   Request fields are held stable until memAck is sampled high; ack may be asserted in the first req cycle.
//   On ack, regIdx+=1. The ack at regIdx==REGS_PER_WIN-1 moves to DONE.
//  FILL: memReq=1, memWrite=0, memAddr=SAVEPTR+regIdx; regWe=memAck; data written to window SWP-1.
//   The ack at the last index moves to DONE.
//  DONE (1 cycle, memReq=0), then IDLE with regIdx=0.
//   Spill: SWP+=1, CWP+=1, SAVEPTR-=REGS_PER_WIN, DEPTH+=1, OCC unchanged.
//   Fill: SWP-=1, CWP-=1, SAVEPTR+=REGS_PER_WIN, DEPTH-=1, OCC unchanged.
//  Latency: a spill/fill with zero-wait ack takes REGS_PER_WIN+1 cycles after accept; stallPipe covers exactly these.
//  WAIT has no effect on SPILL/FILL/DONE progress.
//  Arithmetic: CWP/SWP wrap modulo NWIN; SAVEPTR is plain AW-bit arithmetic, never saturates.
//  Reset mid-operation: memReq, regWe and stallPipe drop asynchronously; every register returns to its reset value.
// CONFIGURATION
//  WINDOW_STATS_EN defined: adds outputs spillCnt[15:0] and fillCnt[15:0].
//   Each increments in DONE of its sequence, saturates at 16'hFFFF and resets to 0.
//  WINDOW_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
//  T1 reset: assert RESET_N=0 mid-cycle -> CWP=0, SWP=0, memReq=0, stallPipe=0 immediately.
//  T2 6 calls -> CWP=6, no memReq. 7th call -> 16 writes, memAddr FFE0..FFEF, regIdx 0..15 (zero-wait ack);
//     then CWP=7, SWP=1, stallPipe high exactly 17 cycles.
//  T3 from T2: 6 returns -> CWP=1, OCC=1. Next return -> 16 reads at FFE0..FFEF, regWe with each ack;
//     then CWP=0, SWP=0, SAVEPTR=FFF0.
//  T4 return straight after reset -> retErr one cycle, CWP/SWP unchanged, memReq=0.
//     Call with WAIT=1 -> ignored. Call+ret together -> no change.
//  T5 spill with random 0-5 cycle ack delay -> memAddr/regIdx stable while memReq && !memAck;
//     call pulses during stall ignored.
//  T6 reset after 5 spill acks -> memReq=0 asynchronously; after release a fresh 7-call run repeats T2 exactly.

Source files
------------

// File: rtl/cwp_window_ctrl.sv
// -----------------------------------------------------------------------------
// cwp_window_ctrl
//   Register-window controller for the CPIPE1 control path. Tracks the current
//   window pointer (CWP), the oldest resident window (SWP), the number of
//   resident windows and the depth of the in-memory save stack. A call that
//   finds every usable window occupied spills the oldest window to memory.
//   A return that finds only one window resident fills the most recently
//   spilled window back. Both transfers use a req/ack handshake and keep the
//   pipeline stalled until they finish.
//
//   Optional feature macro: WINDOW_STATS_EN
//     When defined, adds saturating 16-bit spill/fill completion counters
//     (spillCnt, fillCnt). When undefined, neither the ports nor the
//     counters exist.
// -----------------------------------------------------------------------------
module cwp_window_ctrl #(
    parameter int               NWIN         = 8,
    parameter int               CWPW         = 3,
    parameter int               REGS_PER_WIN = 16,
    parameter int               RIW          = 4,
    parameter int               AW           = 16,
    parameter logic [AW-1:0]    STACK_TOP    = 16'hFFF0
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            WAIT,
    input  logic            changeCWPcall,
    input  logic            changeCWPret,
    input  logic            memAck,
    input  logic [31:0]     memRdata,
    output logic [CWPW-1:0] CWP,
    output logic [CWPW-1:0] SWP,
    output logic            memReq,
    output logic            memWrite,
    output logic [AW-1:0]   memAddr,
    output logic [RIW-1:0]  regIdx,
    output logic [31:0]     memWdata,
    input  logic [31:0]     regRdata,
    output logic            regWe,
    output logic            stallPipe,
    output logic            retErr,
    output logic            stackOvf
`ifdef WINDOW_STATS_EN
    ,
    output logic [15:0]     spillCnt,
    output logic [15:0]     fillCnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPILL = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CWPW-1:0] OCC_MAX   = CWPW'(NWIN - 1);
    localparam logic [CWPW-1:0] OCC_MIN   = CWPW'(1);
    localparam logic [CWPW-1:0] CWP_ONE   = CWPW'(1);
    localparam logic [RIW-1:0]  IDX_LAST  = RIW'(REGS_PER_WIN - 1);
    localparam logic [RIW-1:0]  IDX_ONE   = RIW'(1);
    localparam logic [AW-1:0]   WIN_WORDS = AW'(REGS_PER_WIN);
    localparam logic [7:0]      DEPTH_MAX = 8'd255;

    // Registered state
    state_t          state_r;
    logic [CWPW-1:0] cwp_r;
    logic [CWPW-1:0] swp_r;
    logic [CWPW-1:0] occ_r;
    logic [7:0]      depth_r;
    logic [AW-1:0]   saveptr_r;
    logic [RIW-1:0]  idx_r;
    logic            is_spill_r;
    logic            ret_err_r;
    logic            stk_ovf_r;

    // Next-state values
    state_t          state_s;
    logic [CWPW-1:0] cwp_s;
    logic [CWPW-1:0] swp_s;
    logic [CWPW-1:0] occ_s;
    logic [7:0]      depth_s;
    logic [AW-1:0]   saveptr_s;
    logic [RIW-1:0]  idx_s;
    logic            is_spill_s;
    logic            ret_err_s;
    logic            stk_ovf_s;

    logic            accept_s;
    logic [AW-1:0]   idx_wide_s;
    logic            transfer_s;

    // Fill data travels straight from the memory port to the register-file
    // write port outside this block; it is only folded here so that the
    // port stays formally consumed.
    logic            unused_rdata_s;
    assign unused_rdata_s = ^memRdata;

    assign accept_s   = (state_r == ST_IDLE) && !WAIT && (changeCWPcall ^ changeCWPret);
    assign idx_wide_s = {{(AW-RIW){1'b0}}, idx_r};
    assign transfer_s = (state_r == ST_SPILL) || (state_r == ST_FILL);

    // Output decode: everything except regWe/memWdata comes from registers.
    assign CWP       = cwp_r;
    assign SWP       = swp_r;
    assign regIdx    = idx_r;
    assign memReq    = transfer_s;
    assign memWrite  = (state_r == ST_SPILL);
    assign regWe     = (state_r == ST_FILL) && memAck;
    assign stallPipe = (state_r != ST_IDLE);
    assign memWdata  = regRdata;
    assign retErr    = ret_err_r;
    assign stackOvf  = stk_ovf_r;

    // Transfer address: spills fill the slot just below SAVEPTR, fills read
    // the slot starting at SAVEPTR.
    always_comb begin
        memAddr = {AW{1'b0}};
        case (state_r)
            ST_SPILL: memAddr = saveptr_r - WIN_WORDS + idx_wide_s;
            ST_FILL:  memAddr = saveptr_r + idx_wide_s;
            default:  memAddr = {AW{1'b0}};
        endcase
    end

    // Next-state logic for the controller FSM and its bookkeeping registers.
    always_comb begin
        state_s    = state_r;
        cwp_s      = cwp_r;
        swp_s      = swp_r;
        occ_s      = occ_r;
        depth_s    = depth_r;
        saveptr_s  = saveptr_r;
        idx_s      = idx_r;
        is_spill_s = is_spill_r;
        ret_err_s  = 1'b0;
        stk_ovf_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                idx_s = {RIW{1'b0}};
                if (accept_s && changeCWPcall) begin
                    if (occ_r != OCC_MAX) begin
                        cwp_s = cwp_r + CWP_ONE;
                        occ_s = occ_r + CWP_ONE;
                    end else if (depth_r != DEPTH_MAX) begin
                        state_s    = ST_SPILL;
                        is_spill_s = 1'b1;
                    end else begin
                        stk_ovf_s = 1'b1;
                    end
                end else if (accept_s && changeCWPret) begin
                    if (occ_r != OCC_MIN) begin
                        cwp_s = cwp_r - CWP_ONE;
                        occ_s = occ_r - CWP_ONE;
                    end else if (depth_r != 8'd0) begin
                        state_s    = ST_FILL;
                        is_spill_s = 1'b0;
                    end else begin
                        ret_err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SPILL, ST_FILL: begin
                if (memAck) begin
                    idx_s = idx_r + IDX_ONE;
                    if (idx_r == IDX_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                idx_s   = {RIW{1'b0}};
                if (is_spill_r) begin
                    swp_s     = swp_r + CWP_ONE;
                    cwp_s     = cwp_r + CWP_ONE;
                    saveptr_s = saveptr_r - WIN_WORDS;
                    depth_s   = depth_r + 8'd1;
                end else begin
                    swp_s     = swp_r - CWP_ONE;
                    cwp_s     = cwp_r - CWP_ONE;
                    saveptr_s = saveptr_r + WIN_WORDS;
                    depth_s   = depth_r - 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {RIW{1'b0}};
            end
        endcase
    end

    // State register with asynchronous reset to the idle, empty-stack state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= ST_IDLE;
            cwp_r      <= {CWPW{1'b0}};
            swp_r      <= {CWPW{1'b0}};
            occ_r      <= OCC_MIN;
            depth_r    <= 8'd0;
            saveptr_r  <= STACK_TOP;
            idx_r      <= {RIW{1'b0}};
            is_spill_r <= 1'b0;
            ret_err_r  <= 1'b0;
            stk_ovf_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cwp_r      <= cwp_s;
            swp_r      <= swp_s;
            occ_r      <= occ_s;
            depth_r    <= depth_s;
            saveptr_r  <= saveptr_s;
            idx_r      <= idx_s;
            is_spill_r <= is_spill_s;
            ret_err_r  <= ret_err_s;
            stk_ovf_r  <= stk_ovf_s;
        end
    end

`ifdef WINDOW_STATS_EN
    logic [15:0] spill_cnt_r;
    logic [15:0] fill_cnt_r;

    assign spillCnt = spill_cnt_r;
    assign fillCnt  = fill_cnt_r;

    // Saturating completion counters, bumped in the DONE cycle of each sequence.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            spill_cnt_r <= 16'd0;
            fill_cnt_r  <= 16'd0;
        end else if (state_r == ST_DONE) begin
            if (is_spill_r) begin
                if (spill_cnt_r != 16'hFFFF) begin
                    spill_cnt_r <= spill_cnt_r + 16'd1;
                end else begin
                    spill_cnt_r <= spill_cnt_r;
                end
            end else begin
                if (fill_cnt_r != 16'hFFFF) begin
                    fill_cnt_r <= fill_cnt_r + 16'd1;
                end else begin
                    fill_cnt_r <= fill_cnt_r;
                end
            end
        end else begin
            spill_cnt_r <= spill_cnt_r;
            fill_cnt_r  <= fill_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_cwp_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cwp_window_ctrl
//   Directed plus randomized bench for cwp_window_ctrl. A reference model of
//   the window bookkeeping (plain integers) predicts every pointer, address
//   and strobe; a sparse array stands in for the save-stack memory.
// -----------------------------------------------------------------------------
module tb_cwp_window_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wait_i;
    logic        call_i;
    logic        ret_i;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [2:0]  cwp_o;
    logic [2:0]  swp_o;
    logic        mem_req;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [3:0]  reg_idx;
    logic [31:0] mem_wdata;
    logic [31:0] reg_rdata;
    logic        reg_we;
    logic        stall;
    logic        ret_err;
    logic        stk_ovf;
`ifdef WINDOW_STATS_EN
    logic [15:0] spill_cnt;
    logic [15:0] fill_cnt;
`endif

    cwp_window_ctrl dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .WAIT          (wait_i),
        .changeCWPcall (call_i),
        .changeCWPret  (ret_i),
        .memAck        (mem_ack),
        .memRdata      (mem_rdata),
        .CWP           (cwp_o),
        .SWP           (swp_o),
        .memReq        (mem_req),
        .memWrite      (mem_write),
        .memAddr       (mem_addr),
        .regIdx        (reg_idx),
        .memWdata      (mem_wdata),
        .regRdata      (reg_rdata),
        .regWe         (reg_we),
        .stallPipe     (stall),
        .retErr        (ret_err),
        .stackOvf      (stk_ovf)
`ifdef WINDOW_STATS_EN
        ,
        .spillCnt      (spill_cnt),
        .fillCnt       (fill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the window bookkeeping
    int          m_cwp;
    int          m_swp;
    int          m_occ;
    int          m_depth;
    int          m_sp;
    logic [31:0] stack_mem [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cwp   = 0;
        m_swp   = 0;
        m_occ   = 1;
        m_depth = 0;
        m_sp    = 32'hFFF0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_cwp"}, 32'(cwp_o), 32'(m_cwp));
        chk({tag, "_swp"}, 32'(swp_o), 32'(m_swp));
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        call_i  = 1'b0;
        ret_i   = 1'b0;
        wait_i  = 1'b0;
        #1;
        chk({tag, "_req"},   32'(mem_req), 32'd0);
        chk({tag, "_stall"}, 32'(stall),   32'd0);
        chk({tag, "_we"},    32'(reg_we),  32'd0);
        chk({tag, "_idx"},   32'(reg_idx), 32'd0);
        model_reset();
        chk_state(tag);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Runs one spill or fill; returns early if abort_at matches the index.
    task automatic xfer(input bit is_spill, input int maxd, input int abort_at);
        int base;
        int d;
        int dsum;
        int stall_seen;
        bit ack;
        base       = is_spill ? ((m_sp - 16) & 32'hFFFF) : m_sp;
        dsum       = 0;
        stall_seen = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == abort_at) begin
                async_reset("abort");
                return;
            end
            d    = (maxd == 0) ? 0 : int'($urandom_range(0, maxd));
            dsum = dsum + d;
            for (int j = 0; j <= d; j++) begin
                ack       = (j == d);
                mem_ack   = ack;
                call_i    = ack ? 1'b0 : 1'($urandom_range(0, 1));
                wait_i    = 1'($urandom_range(0, 1));
                reg_rdata = $urandom;
                mem_rdata = stack_mem.exists(base + k) ? stack_mem[base + k] : 32'd0;
                #1;
                chk("xfer_req",  32'(mem_req),   32'd1);
                chk("xfer_wr",   32'(mem_write), 32'(is_spill));
                chk("xfer_addr", 32'(mem_addr),  32'((base + k) & 32'hFFFF));
                chk("xfer_idx",  32'(reg_idx),   32'(k));
                chk("xfer_we",   32'(reg_we),    (is_spill || !ack) ? 32'd0 : 32'd1);
                if (is_spill) begin
                    chk("xfer_wdata", mem_wdata, reg_rdata);
                    if (ack) begin
                        stack_mem[base + k] = reg_rdata;
                    end
                end
                stall_seen = stall_seen + int'(stall);
                step();
            end
        end
        mem_ack = 1'b0;
        call_i  = 1'b0;
        wait_i  = 1'b0;
        chk("done_stall", 32'(stall),   32'd1);
        chk("done_req",   32'(mem_req), 32'd0);
        stall_seen = stall_seen + int'(stall);
        step();
        if (is_spill) begin
            m_swp   = (m_swp + 1) % 8;
            m_cwp   = (m_cwp + 1) % 8;
            m_sp    = (m_sp - 16) & 32'hFFFF;
            m_depth = m_depth + 1;
        end else begin
            m_swp   = (m_swp + 7) % 8;
            m_cwp   = (m_cwp + 7) % 8;
            m_sp    = (m_sp + 16) & 32'hFFFF;
            m_depth = m_depth - 1;
        end
        chk_state("post_xfer");
        chk("post_stall",  32'(stall),      32'd0);
        chk("post_idx",    32'(reg_idx),    32'd0);
        chk("stall_len",   32'(stall_seen), 32'(17 + dsum));
    endtask

    // Issue one call/ret pulse and check the predicted outcome.
    task automatic do_cmd(input bit c, input bit r, input bit w, input int maxd, input int abort_at);
        int kind; // 0 ignored, 1 move, 2 spill, 3 fill, 4 overflow, 5 return error
        kind = 0;
        if (!w && (c != r)) begin
            if (c) begin
                kind = (m_occ < 7) ? 1 : ((m_depth < 255) ? 2 : 4);
            end else begin
                kind = (m_occ > 1) ? 1 : ((m_depth > 0) ? 3 : 5);
            end
        end
        call_i = c;
        ret_i  = r;
        wait_i = w;
        step();
        call_i = 1'b0;
        ret_i  = 1'b0;
        wait_i = 1'b0;
        if (kind == 2 || kind == 3) begin
            chk("acc_stall", 32'(stall), 32'd1);
            xfer(kind == 2, maxd, abort_at);
        end else begin
            if (kind == 1) begin
                m_cwp = c ? (m_cwp + 1) % 8 : (m_cwp + 7) % 8;
                m_occ = c ? m_occ + 1 : m_occ - 1;
            end
            chk_state("cmd");
            chk("cmd_stall",  32'(stall),   32'd0);
            chk("cmd_req",    32'(mem_req), 32'd0);
            chk("cmd_reterr", 32'(ret_err), (kind == 5) ? 32'd1 : 32'd0);
            chk("cmd_ovf",    32'(stk_ovf), (kind == 4) ? 32'd1 : 32'd0);
            if (kind == 4 || kind == 5) begin
                step();
                chk("pulse_end_err", 32'(ret_err), 32'd0);
                chk("pulse_end_ovf", 32'(stk_ovf), 32'd0);
                chk_state("pulse_end");
            end
        end
    endtask

    initial begin
        int sel;
        rst_n     = 1'b0;
        wait_i    = 1'b0;
        call_i    = 1'b0;
        ret_i     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        reg_rdata = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_state("reset");
        chk("reset_req",   32'(mem_req),   32'd0);
        chk("reset_wr",    32'(mem_write), 32'd0);
        chk("reset_stall", 32'(stall),     32'd0);
        chk("reset_idx",   32'(reg_idx),   32'd0);
        chk("reset_err",   32'(ret_err),   32'd0);
        chk("reset_ovf",   32'(stk_ovf),   32'd0);
        rst_n = 1'b1;
        step();

        // Return with nothing resident, call under WAIT, call+ret together
        do_cmd(1'b0, 1'b1, 1'b0, 0, -1);
        do_cmd(1'b1, 1'b0, 1'b1, 0, -1);
        do_cmd(1'b1, 1'b1, 1'b0, 0, -1);

        // Mid-cycle reset after two calls
        do_cmd(1'b1, 1'b0, 1'b0, 0, -1);
        do_cmd(1'b1, 1'b0, 1'b0, 0, -1);
        async_reset("t1");

        // Six calls, then a zero-wait spill; six returns, then a zero-wait fill
        for (int i = 0; i < 7; i++) do_cmd(1'b1, 1'b0, 1'b0, 0, -1);
        for (int i = 0; i < 7; i++) do_cmd(1'b0, 1'b1, 1'b0, 0, -1);
        chk("sp_restored", 32'(m_sp), 32'hFFF0);

        // Reset after five spill acks, then a clean repeat of the spill run
        for (int i = 0; i < 7; i++) do_cmd(1'b1, 1'b0, 1'b0, 0, (i == 6) ? 5 : -1);
        for (int i = 0; i < 7; i++) do_cmd(1'b1, 1'b0, 1'b0, 0, -1);

        // Randomized call/ret traffic with random ack delays
        for (int i = 0; i < 120; i++) begin
            sel = int'($urandom_range(0, 9));
            do_cmd(sel <= 4 || sel == 9, sel >= 5, ($urandom_range(0, 7) == 0), 5, -1);
        end

        // Fill the save stack to its limit, then check overflow and a fill-back
        async_reset("t7");
        for (int i = 0; i < 6 + 255; i++) do_cmd(1'b1, 1'b0, 1'b0, 0, -1);
        chk("depth_full", 32'(m_depth), 32'd255);
        do_cmd(1'b1, 1'b0, 1'b0, 0, -1);
        for (int i = 0; i < 8; i++) do_cmd(1'b0, 1'b1, 1'b0, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
